// File: rtl/register_file.sv
// General-purpose 32 x 64-bit register file for the RISC-V datapath: two read ports, one write port.
// Latency: reads are combinational (zero cycles); a write is visible right after its capturing edge.
// Backpressure: none; every write is accepted on the edge where it is enabled.
//
// Ports:
//   clk         system clock; writes capture on the rising edge
//   rst         asynchronous active-high reset; clears every register at once
//   reg_num_r0  read port 0 register number  -> r_data_0
//   reg_num_r1  read port 1 register number  -> r_data_1
//   reg_num_w   write port register number
//   w_data      write data
//   ctrl_reg_w  write enable, active high
//
// Register 0 is ordinary storage; x0 zero semantics are handled by decode/control.
module register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] reg_num_r0,
  input  logic [ADDR_WIDTH-1:0] reg_num_r1,
  input  logic [ADDR_WIDTH-1:0] reg_num_w,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  ctrl_reg_w,
  output logic [DATA_WIDTH-1:0] r_data_0,
  output logic [DATA_WIDTH-1:0] r_data_1
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Reset clears the whole array asynchronously, so the read outputs are 0
  // for as long as rst is held and no register is ever left undefined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (ctrl_reg_w) begin
      regs[reg_num_w] <= w_data;
    end
  end

  // No write-through bypass: a same-index read returns the old value until
  // the capturing edge has updated the array.
  assign r_data_0 = regs[reg_num_r0];
  assign r_data_1 = regs[reg_num_r1];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] reg_num_r0 = '0;
  logic [AW-1:0] reg_num_r1 = '0;
  logic [AW-1:0] reg_num_w  = '0;
  logic [DW-1:0] w_data     = '0;
  logic          ctrl_reg_w = 1'b0;
  logic [DW-1:0] r_data_0;
  logic [DW-1:0] r_data_1;

  int n_checks = 0;
  int n_fail   = 0;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_num_r0 (reg_num_r0),
    .reg_num_r1 (reg_num_r1),
    .reg_num_w  (reg_num_w),
    .w_data     (w_data),
    .ctrl_reg_w (ctrl_reg_w),
    .r_data_0   (r_data_0),
    .r_data_1   (r_data_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wnum;
    logic [DW-1:0] wdata;
    logic [AW-1:0] r0;
    logic [AW-1:0] r1;
    logic [DW-1:0] exp0;
    logic [DW-1:0] exp1;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [AW-1:0] num, input logic [DW-1:0] data);
    @(negedge clk);
    ctrl_reg_w = 1'b1;
    reg_num_w  = num;
    w_data     = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Register contents expected once the hand sequences below have run:
    // r4=123, r13=42069, r0=7777, all others 0.
    vecs[0] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vecs[1] = '{1'b1, 5'd30, 64'hA5A5_5A5A_DEAD_BEEF, 5'd30, 5'd31, 64'hA5A5_5A5A_DEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2] = '{1'b0, 5'd31, 64'h0000_0000_0000_0055, 5'd31, 5'd4,  64'hFFFF_FFFF_FFFF_FFFF, 64'd123};
    vecs[3] = '{1'b1, 5'd13, 64'd1,                   5'd13, 5'd13, 64'd1,                   64'd1};
    vecs[4] = '{1'b1, 5'd7,  64'h8000_0000_0000_0000, 5'd7,  5'd0,  64'h8000_0000_0000_0000, 64'd7777};
    vecs[5] = '{1'b0, 5'd7,  64'h0,                   5'd7,  5'd13, 64'h8000_0000_0000_0000, 64'd1};
    vecs[6] = '{1'b1, 5'd0,  64'h0123_4567_89AB_CDEF, 5'd0,  5'd4,  64'h0123_4567_89AB_CDEF, 64'd123};
    vecs[7] = '{1'b1, 5'd4,  64'h0,                   5'd4,  5'd31, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF};

    // 1. Reset, release, scan all indices on both ports.
    #2 rst = 1'b1;
    #1 check("reset_held_r0", r_data_0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      reg_num_r0 = AW'(i);
      reg_num_r1 = AW'(31 - i);
      #1;
      check($sformatf("reset_scan_p0_r%0d", i), r_data_0, '0);
      check($sformatf("reset_scan_p1_r%0d", 31 - i), r_data_1, '0);
    end

    // 2. Write r4 then r13 on consecutive edges.
    write_reg(5'd4, 64'd123);
    write_reg(5'd13, 64'd42069);
    @(negedge clk);
    ctrl_reg_w = 1'b0;
    reg_num_r0 = 5'd4;
    reg_num_r1 = 5'd13;
    #1;
    check("wr_r4", r_data_0, 64'd123);
    check("wr_r13", r_data_1, 64'd42069);

    // 3. Register 0 is writable.
    write_reg(5'd0, 64'd1234);
    reg_num_r0 = 5'd0;
    reg_num_r1 = 5'd0;
    #1;
    check("r0_write_p0", r_data_0, 64'd1234);
    check("r0_write_p1", r_data_1, 64'd1234);

    // 4. Write held enabled; new data shows only after the next edge.
    @(negedge clk);
    w_data = 64'd7777;
    #1;
    check("rdw_before_p0", r_data_0, 64'd1234);
    check("rdw_before_p1", r_data_1, 64'd1234);
    @(posedge clk);
    #1;
    check("rdw_after_p0", r_data_0, 64'd7777);
    check("rdw_after_p1", r_data_1, 64'd7777);

    // 5. Write disabled across several edges leaves r4 untouched.
    @(negedge clk);
    ctrl_reg_w = 1'b0;
    reg_num_w  = 5'd4;
    w_data     = 64'd555;
    reg_num_r0 = 5'd4;
    reg_num_r1 = 5'd4;
    repeat (4) @(posedge clk);
    #1;
    check("we0_r4_p0", r_data_0, 64'd123);
    check("we0_r4_p1", r_data_1, 64'd123);

    // Table-driven vectors: apply, clock once, compare.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      ctrl_reg_w = vecs[v].we;
      reg_num_w  = vecs[v].wnum;
      w_data     = vecs[v].wdata;
      reg_num_r0 = vecs[v].r0;
      reg_num_r1 = vecs[v].r1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_p0", v), r_data_0, vecs[v].exp0);
      check($sformatf("vec%0d_p1", v), r_data_1, vecs[v].exp1);
    end

    // 6. Preload r4/r13, then assert reset between edges with a write pending.
    write_reg(5'd4, 64'd123);
    write_reg(5'd13, 64'd42069);
    @(negedge clk);
    ctrl_reg_w = 1'b0;
    reg_num_r0 = 5'd4;
    reg_num_r1 = 5'd13;
    #1;
    check("preload_r4", r_data_0, 64'd123);
    check("preload_r13", r_data_1, 64'd42069);
    #1;
    ctrl_reg_w = 1'b1;
    reg_num_w  = 5'd4;
    w_data     = 64'd99;
    rst        = 1'b1;
    #1;
    check("async_rst_r4", r_data_0, '0);
    check("async_rst_r13", r_data_1, '0);
    // Reset held across an enabled write edge must win.
    @(posedge clk);
    #1;
    check("rst_vs_write_r4", r_data_0, '0);
    @(negedge clk);
    ctrl_reg_w = 1'b0;
    rst        = 1'b0;
    #1;
    check("post_rst_r4", r_data_0, '0);
    check("post_rst_r13", r_data_1, '0);
    reg_num_r0 = 5'd31;
    reg_num_r1 = 5'd0;
    #1;
    check("post_rst_r31", r_data_0, '0);
    check("post_rst_r0", r_data_1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
